pci_la_capture: RTL and testbench
=================================

PCI_LA_CAPTURE -- requirements
Module: pci_la_capture

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of capture depth (DEPTH = 256 samples).
REQ-002 Parameter PRE, default 16, pre-trigger sample count; legal range 0..DEPTH-1.
REQ-003 Parameter WIDTH, default 48, sample width (PCI AD/CBE/control snapshot).
REQ-004 PCI_CLK  in  1  sole clock; all logic on rising edge.
REQ-005 PCI_RSTn  in  1  reset, synchronous, active-low.
REQ-006 sample_in  in  WIDTH  bus snapshot, sampled every cycle.
REQ-007 trigger  in  1  trigger qualifier (e.g. target-claimed start), level-sampled.
REQ-008 arm  in  1  one-cycle pulse; starts a new capture.
REQ-009 abort  in  1  one-cycle pulse; cancels capture.
REQ-010 rd_en  in  1  readout request, one word per asserted cycle.
REQ-011 rd_data  out  WIDTH  readout word.
REQ-012 rd_valid  out  1  rd_data qualifier.
REQ-013 state  out  3  current FSM state encoding.
REQ-014 done  out  1  capture complete, buffer readable.
REQ-015 trig_addr  out  DEPTH_LOG2  buffer address of trigger sample.

Function
REQ-016 FSM states: IDLE, PRETRIG, WAITTRIG, POST, DONE.
REQ-017 IDLE: no writes; arm -> PRETRIG, write pointer and sample counter cleared.
REQ-018 PRETRIG: write sample_in every cycle, wptr+1; after PRE writes -> WAITTRIG; PRE=0 goes directly to WAITTRIG on the next cycle; trigger ignored.
REQ-019 WAITTRIG: write every cycle, wptr wraps modulo DEPTH; trigger=1 -> that cycle's sample written at wptr, trig_addr<=wptr, -> POST.
REQ-020 POST: write every cycle; after DEPTH-PRE-1 further writes -> DONE; total samples from trigger inclusive = DEPTH-PRE.
REQ-021 DONE: writes stop; done=1; arm -> PRETRIG (new capture); otherwise hold.
REQ-022 abort in any state -> IDLE next cycle, done=0; abort wins over simultaneous arm or trigger.
REQ-023 arm in PRETRIG/WAITTRIG/POST restarts at PRETRIG with cleared pointers.
REQ-024 Read pointer loads trig_addr-PRE (mod DEPTH) on entry to DONE, i.e. oldest sample first.
REQ-025 rd_en in DONE: rd_data = RAM[rptr] registered, rd_valid=1 exactly one cycle later, rptr+1 mod DEPTH (wraps to oldest after DEPTH reads).
REQ-026 rd_en outside DONE ignored; rd_valid stays 0, rptr unchanged.
REQ-027 Buffer storage: single-port-write, registered-read RAM, DEPTH x WIDTH, inferable as blockram.
REQ-028 Pointer arithmetic strictly DEPTH_LOG2 bits, natural wrap; no overflow flags.

Reset
REQ-029 On PCI_RSTn=0 at a clock edge: state=IDLE, done=0, rd_valid=0, trig_addr=0, rd_data=0, all pointers/counters 0.
REQ-030 Reset mid-capture abandons capture; RAM contents not cleared.
REQ-031 Reset overrides arm, abort, trigger, rd_en.

Structure
REQ-032 Shared package holds state enumeration and default DEPTH_LOG2/PRE/WIDTH constants.
REQ-033 One sub-module: la_capture_ram (DEPTH x WIDTH, write port + registered read port).
REQ-034 No clock-domain crossing inside the block; external readout logic handles other clocks.

Verification
REQ-035 Reset, arm, sample_in=cycle count, trigger at sample 100 -> trig_addr=100, DONE after 240 more cycles, first read = value 84, 256th read = value 339.
REQ-036 Trigger asserted during PRETRIG (cycles 1..15 after arm) -> ignored; first trigger in WAITTRIG recorded.
REQ-037 Trigger after wptr wraps (sample 300) -> trig_addr=44, first read = value 284.
REQ-038 abort in POST with arm same cycle -> IDLE, done=0, no further writes.
REQ-039 rd_en held in WAITTRIG -> rd_valid=0; in DONE, 257 reads -> read 257 equals read 1.
REQ-040 PCI_RSTn low for one cycle during POST -> all outputs at REQ-029 values next cycle.

Source files
------------

// File: rtl/pci_la_capture_pkg.sv
// Shared types and default sizing for the PCI logic-analyzer capture block.
package pci_la_capture_pkg;

  localparam int DEF_DEPTH_LOG2 = 8;
  localparam int DEF_PRE        = 16;
  localparam int DEF_WIDTH      = 48;

  typedef enum logic [2:0] {
    LA_IDLE     = 3'd0,
    LA_PRETRIG  = 3'd1,
    LA_WAITTRIG = 3'd2,
    LA_POST     = 3'd3,
    LA_DONE     = 3'd4
  } la_state_e;

endpackage

// File: rtl/pci_la_capture_if.sv
// Capture control / readout bundle; master drives stimulus and reads, slave is the capture block.
interface pci_la_capture_if
  import pci_la_capture_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
);
  logic [WIDTH-1:0]      sample_in;
  logic                  trigger;
  logic                  arm;
  logic                  abort;
  logic                  rd_en;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic [2:0]            state;
  logic                  done;
  logic [DEPTH_LOG2-1:0] trig_addr;

  modport master (
    output sample_in, trigger, arm, abort, rd_en,
    input  rd_data, rd_valid, state, done, trig_addr
  );

  modport slave (
    input  sample_in, trigger, arm, abort, rd_en,
    output rd_data, rd_valid, state, done, trig_addr
  );
endinterface

// File: rtl/pci_la_capture_ram.sv
// Capture buffer: one write port, one registered read port, blockram-inferable.
module la_capture_ram #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WIDTH      = 48
) (
  input  logic                  PCI_CLK,
  input  logic                  PCI_RSTn,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge PCI_CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register carries a sync reset only; array contents survive reset.
  always_ff @(posedge PCI_CLK) begin
    if (!PCI_RSTn)  rdata <= '0;
    else if (re)    rdata <= mem[raddr];
  end
endmodule

// File: rtl/pci_la_capture.sv
// Circular pre/post-trigger capture of PCI bus snapshots with oldest-first readout.
module pci_la_capture
  import pci_la_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int PRE        = DEF_PRE,
  parameter int WIDTH      = DEF_WIDTH
) (
  input  logic            PCI_CLK,
  input  logic            PCI_RSTn,
  pci_la_capture_if.slave bus
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int POST_N = DEPTH - PRE - 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PRE_A     = DEPTH_LOG2'(PRE);
  localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE - 1);
  localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_N - 1);

  la_state_e             st;
  logic [DEPTH_LOG2-1:0] wptr, rptr, cnt, trig_q;
  logic                  done_q, rvld_q;
  logic                  we, rd_go;

  // The abort/arm cycle writes nothing so a cancelled capture leaves the buffer untouched.
  assign we = !bus.abort && !bus.arm &&
              ((st == LA_PRETRIG && PRE != 0) || st == LA_WAITTRIG || st == LA_POST);
  assign rd_go = (st == LA_DONE) && bus.rd_en && !bus.abort;

  always_ff @(posedge PCI_CLK) begin
    if (!PCI_RSTn) begin
      st     <= LA_IDLE;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      trig_q <= '0;
      done_q <= 1'b0;
      rvld_q <= 1'b0;
    end else begin
      rvld_q <= rd_go;
      if (rd_go) rptr <= rptr + PTR_ONE;
      if (bus.abort) begin
        st     <= LA_IDLE;
        done_q <= 1'b0;
      end else if (bus.arm) begin
        st     <= LA_PRETRIG;
        wptr   <= '0;
        cnt    <= '0;
        done_q <= 1'b0;
      end else begin
        case (st)
          LA_PRETRIG: begin
            if (PRE == 0) begin
              st <= LA_WAITTRIG;
            end else begin
              wptr <= wptr + PTR_ONE;
              cnt  <= cnt + PTR_ONE;
              if (cnt == PRE_LAST) begin
                st  <= LA_WAITTRIG;
                cnt <= '0;
              end
            end
          end
          LA_WAITTRIG: begin
            wptr <= wptr + PTR_ONE;
            if (bus.trigger) begin
              trig_q <= wptr;
              cnt    <= '0;
              // PRE = DEPTH-1 leaves no post-trigger writes after the trigger sample.
              if (POST_N == 0) begin
                st     <= LA_DONE;
                done_q <= 1'b1;
                rptr   <= wptr - PRE_A;
              end else begin
                st <= LA_POST;
              end
            end
          end
          LA_POST: begin
            wptr <= wptr + PTR_ONE;
            cnt  <= cnt + PTR_ONE;
            if (cnt == POST_LAST) begin
              st     <= LA_DONE;
              done_q <= 1'b1;
              rptr   <= trig_q - PRE_A;
            end
          end
          default: ;
        endcase
      end
    end
  end

  la_capture_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_ram (
    .PCI_CLK  (PCI_CLK),
    .PCI_RSTn (PCI_RSTn),
    .we       (we),
    .waddr    (wptr),
    .wdata    (bus.sample_in),
    .re       (rd_go),
    .raddr    (rptr),
    .rdata    (bus.rd_data)
  );

  assign bus.rd_valid  = rvld_q;
  assign bus.state     = st;
  assign bus.done      = done_q;
  assign bus.trig_addr = trig_q;
endmodule

// File: tb/tb_pci_la_capture.sv
// Directed checks of capture, trigger placement, abort/reset and oldest-first readout.
module tb_pci_la_capture;
  import pci_la_capture_pkg::*;

  localparam int WIDTH      = 48;
  localparam int DEPTH_LOG2 = 8;

  logic PCI_CLK;
  logic PCI_RSTn;
  int   n_chk  = 0;
  int   n_fail = 0;

  pci_la_capture_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  pci_la_capture #(.DEPTH_LOG2(DEPTH_LOG2), .PRE(16), .WIDTH(WIDTH)) dut (
    .PCI_CLK  (PCI_CLK),
    .PCI_RSTn (PCI_RSTn),
    .bus      (bus)
  );

  initial PCI_CLK = 1'b0;
  always #5 PCI_CLK = ~PCI_CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCI_CLK);
    #1;
  endtask

  // Drive n consecutive samples starting at value v0; trigger high while value in [lo,hi].
  task automatic feed(input int v0, input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      bus.sample_in = WIDTH'(v0 + i);
      bus.trigger   = (v0 + i >= lo) && (v0 + i <= hi);
      step();
    end
    bus.trigger = 1'b0;
  endtask

  task automatic rd_run(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      bus.rd_en = 1'b1;
      step();
      chk("rd_valid", 64'(bus.rd_valid), 64'd1);
      chk("rd_data", 64'(bus.rd_data), 64'(first + i));
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    chk("arm_state", 64'(bus.state), 64'(LA_PRETRIG));
  endtask

  initial begin
    PCI_RSTn      = 1'b0;
    bus.sample_in = '0;
    bus.trigger   = 1'b0;
    bus.arm       = 1'b0;
    bus.abort     = 1'b0;
    bus.rd_en     = 1'b0;
    step();
    step();
    chk("rst_state", 64'(bus.state), 64'(LA_IDLE));
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_trig_addr", 64'(bus.trig_addr), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    PCI_RSTn = 1'b1;
    step();

    // Trigger at sample 100: oldest = 84, newest = 339.
    do_arm();
    feed(0, 16, -1, -1);
    chk("t1_waittrig", 64'(bus.state), 64'(LA_WAITTRIG));
    feed(16, 85, 100, 100);
    chk("t1_post", 64'(bus.state), 64'(LA_POST));
    chk("t1_trig_addr", 64'(bus.trig_addr), 64'd100);
    feed(101, 238, -1, -1);
    chk("t1_still_post", 64'(bus.state), 64'(LA_POST));
    chk("t1_not_done", 64'(bus.done), 64'd0);
    feed(339, 1, -1, -1);
    chk("t1_done_state", 64'(bus.state), 64'(LA_DONE));
    chk("t1_done", 64'(bus.done), 64'd1);
    rd_run(256, 84);
    step();
    chk("t1_rd_idle", 64'(bus.rd_valid), 64'd0);
    rd_run(1, 84);

    // Triggers during pre-trigger fill are ignored; rd_en outside DONE does nothing.
    do_arm();
    feed(0, 16, 1, 15);
    chk("t2_waittrig", 64'(bus.state), 64'(LA_WAITTRIG));
    bus.rd_en = 1'b1;
    feed(16, 24, -1, -1);
    chk("t2_rd_valid_wait", 64'(bus.rd_valid), 64'd0);
    chk("t2_rd_data_hold", 64'(bus.rd_data), 64'd84);
    bus.rd_en = 1'b0;
    feed(40, 1, 40, 40);
    chk("t2_trig_addr", 64'(bus.trig_addr), 64'd40);
    feed(41, 239, -1, -1);
    chk("t2_done", 64'(bus.done), 64'd1);
    rd_run(2, 24);

    // Trigger after the write pointer has wrapped.
    do_arm();
    feed(0, 300, -1, -1);
    chk("t3_waittrig", 64'(bus.state), 64'(LA_WAITTRIG));
    feed(300, 1, 300, 300);
    chk("t3_trig_addr", 64'(bus.trig_addr), 64'd44);
    feed(301, 239, -1, -1);
    chk("t3_done", 64'(bus.done), 64'd1);
    rd_run(2, 284);

    // Abort beats a simultaneous arm in POST.
    do_arm();
    feed(0, 101, 100, 100);
    feed(101, 10, -1, -1);
    chk("t4_post", 64'(bus.state), 64'(LA_POST));
    bus.abort = 1'b1;
    bus.arm   = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.arm   = 1'b0;
    chk("t4_idle", 64'(bus.state), 64'(LA_IDLE));
    chk("t4_done", 64'(bus.done), 64'd0);
    bus.rd_en = 1'b1;
    feed(111, 20, 115, 115);
    bus.rd_en = 1'b0;
    chk("t4_stay_idle", 64'(bus.state), 64'(LA_IDLE));
    chk("t4_trig_hold", 64'(bus.trig_addr), 64'd100);
    chk("t4_rd_valid", 64'(bus.rd_valid), 64'd0);

    // One-cycle reset in POST returns every output to its reset value.
    do_arm();
    feed(0, 101, 100, 100);
    feed(101, 5, -1, -1);
    chk("t5_post", 64'(bus.state), 64'(LA_POST));
    PCI_RSTn = 1'b0;
    step();
    PCI_RSTn = 1'b1;
    chk("t5_state", 64'(bus.state), 64'(LA_IDLE));
    chk("t5_done", 64'(bus.done), 64'd0);
    chk("t5_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("t5_trig_addr", 64'(bus.trig_addr), 64'd0);
    chk("t5_rd_data", 64'(bus.rd_data), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
